// File: rtl/vga_scanout_pkg.sv
// Shared widths, pipeline flag bundle and colour expansion for the VGA scan-out path.
package vga_scanout_pkg;
    localparam int BLK_W    = 3;
    localparam int PIX_W    = 6;
    localparam int ADDR_W   = 18;
    localparam int IMG_W    = BLK_W + PIX_W;
    localparam int IMG_SIZE = 1 << IMG_W;
    localparam int HCNT_W   = 11;
    localparam int VCNT_W   = 10;

    typedef struct packed {
        logic [3:0] r;
        logic [3:0] g;
        logic [3:0] b;
    } rgb444_t;

    typedef struct packed {
        logic active;
        logic in_img;
        logic hs;
        logic vs;
        logic sof;
    } pix_flags_t;

    // MSBs are replicated into the low bits so full-scale 332 maps to full-scale 444.
    function automatic rgb444_t rgb332_to_444(input logic [7:0] p);
        rgb444_t c;
        c.r = {p[7:5], p[7]};
        c.g = {p[4:2], p[4]};
        c.b = {p[1:0], p[1:0]};
        return c;
    endfunction
endpackage

// File: rtl/vga_scanout_if.sv
// Fixed-latency read path to the tile array: no valid/ready, data for an address
// returns a fixed number of clocks later and the scan-out never stalls.
interface vga_scanout_if;
    import vga_scanout_pkg::*;

    logic [ADDR_W-1:0] global_addr;
    logic [7:0]        global_rd_data;

    modport master (output global_addr, input global_rd_data);
    modport slave  (input global_addr, output global_rd_data);
endinterface

// File: rtl/vga_timing_gen.sv
// Raster counters with registered active/sync/start-of-frame decode aligned to the counts.
module vga_timing_gen
    import vga_scanout_pkg::*;
#(
    parameter int H_ACTIVE = 800,
    parameter int H_FP     = 40,
    parameter int H_SYNC   = 128,
    parameter int H_BP     = 88,
    parameter int V_ACTIVE = 600,
    parameter int V_FP     = 1,
    parameter int V_SYNC   = 4,
    parameter int V_BP     = 23
) (
    input  logic              clk,
    input  logic              reset,
    output logic [HCNT_W-1:0] hcnt,
    output logic [VCNT_W-1:0] vcnt,
    output logic              active,
    output logic              hs_raw,
    output logic              vs_raw,
    output logic              sof
);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [HCNT_W-1:0] H_LAST = HCNT_W'(H_TOTAL - 1);
    localparam logic [HCNT_W-1:0] H_ACT  = HCNT_W'(H_ACTIVE);
    localparam logic [HCNT_W-1:0] HS_BEG = HCNT_W'(H_ACTIVE + H_FP);
    localparam logic [HCNT_W-1:0] HS_END = HCNT_W'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [VCNT_W-1:0] V_LAST = VCNT_W'(V_TOTAL - 1);
    localparam logic [VCNT_W-1:0] V_ACT  = VCNT_W'(V_ACTIVE);
    localparam logic [VCNT_W-1:0] VS_BEG = VCNT_W'(V_ACTIVE + V_FP);
    localparam logic [VCNT_W-1:0] VS_END = VCNT_W'(V_ACTIVE + V_FP + V_SYNC);

    logic [HCNT_W-1:0] hcnt_d, hcnt_q;
    logic [VCNT_W-1:0] vcnt_d, vcnt_q;
    logic active_d, active_q, hs_d, hs_q, vs_d, vs_q, sof_d, sof_q;

    // Decode is taken from the next count so the flags land in the same cycle as the counts.
    always_comb begin
        hcnt_d = hcnt_q + HCNT_W'(1);
        vcnt_d = vcnt_q;
        if (hcnt_q == H_LAST) begin
            hcnt_d = '0;
            vcnt_d = (vcnt_q == V_LAST) ? '0 : vcnt_q + VCNT_W'(1);
        end
        if (reset) begin
            hcnt_d = '0;
            vcnt_d = '0;
        end
        active_d = (hcnt_d < H_ACT) && (vcnt_d < V_ACT);
        hs_d     = (hcnt_d >= HS_BEG) && (hcnt_d < HS_END);
        vs_d     = (vcnt_d >= VS_BEG) && (vcnt_d < VS_END);
        sof_d    = (hcnt_d == '0) && (vcnt_d == '0);
    end

    always_ff @(posedge clk) begin
        hcnt_q   <= hcnt_d;
        vcnt_q   <= vcnt_d;
        active_q <= active_d;
        hs_q     <= hs_d;
        vs_q     <= vs_d;
        sof_q    <= sof_d;
    end

    assign hcnt   = hcnt_q;
    assign vcnt   = vcnt_q;
    assign active = active_q;
    assign hs_raw = hs_q;
    assign vs_raw = vs_q;
    assign sof    = sof_q;
endmodule

// File: rtl/vga_scanout.sv
// Scan-out top: image-window address mapping, flag delay line matching the array read
// latency, and the registered RGB/sync/frame_start pins.
module vga_scanout
    import vga_scanout_pkg::*;
#(
    parameter int          H_ACTIVE   = 800,
    parameter int          H_FP       = 40,
    parameter int          H_SYNC     = 128,
    parameter int          H_BP       = 88,
    parameter int          V_ACTIVE   = 600,
    parameter int          V_FP       = 1,
    parameter int          V_SYNC     = 4,
    parameter int          V_BP       = 23,
    parameter int          SYNC_POL   = 1,
    parameter int          IMG_X0     = 144,
    parameter int          IMG_Y0     = 44,
    parameter int          RD_LATENCY = 2,
    parameter logic [11:0] BORDER_RGB = 12'h000
) (
    input  logic              clk,
    input  logic              reset,
    vga_scanout_if.master     arr,
    output logic [3:0]        vga_r,
    output logic [3:0]        vga_g,
    output logic [3:0]        vga_b,
    output logic              vga_hs,
    output logic              vga_vs,
    output logic              frame_start
);
    localparam logic SYNC_ACT = (SYNC_POL != 0);

    logic [HCNT_W-1:0] hcnt;
    logic [VCNT_W-1:0] vcnt;
    logic              active, hs_raw, vs_raw, sof;

    vga_timing_gen #(
        .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
        .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP)
    ) u_timing (
        .clk(clk), .reset(reset),
        .hcnt(hcnt), .vcnt(vcnt),
        .active(active), .hs_raw(hs_raw), .vs_raw(vs_raw), .sof(sof)
    );

    logic [HCNT_W:0]   dx;
    logic [VCNT_W:0]   dy;
    logic              in_img;
    pix_flags_t        s0;
    logic [ADDR_W-1:0] addr_d, addr_q;

    // Positions left of / above the window wrap to large values, so one unsigned compare
    // per axis covers both edges of the window.
    always_comb begin
        dx     = {1'b0, hcnt} - (HCNT_W + 1)'(IMG_X0);
        dy     = {1'b0, vcnt} - (VCNT_W + 1)'(IMG_Y0);
        in_img = active && (dx < (HCNT_W + 1)'(IMG_SIZE)) && (dy < (VCNT_W + 1)'(IMG_SIZE));
        s0     = '{active: active, in_img: in_img, hs: hs_raw, vs: vs_raw, sof: sof};
        addr_d = '0;
        if (in_img)
            addr_d = {dy[PIX_W +: BLK_W], dx[PIX_W +: BLK_W], dy[0 +: PIX_W], dx[0 +: PIX_W]};
        if (reset)
            addr_d = '0;
    end

    pix_flags_t dly_d [RD_LATENCY];
    pix_flags_t dly_q [RD_LATENCY];
    pix_flags_t aligned;

    always_comb begin
        dly_d[0] = s0;
        for (int i = 1; i < RD_LATENCY; i++)
            dly_d[i] = dly_q[i-1];
        if (reset)
            for (int i = 0; i < RD_LATENCY; i++)
                dly_d[i] = '0;
    end

    assign aligned = dly_q[RD_LATENCY-1];

    rgb444_t rgb_d, rgb_q;
    logic    hs_d, hs_q, vs_d, vs_q, fs_d, fs_q;

    always_comb begin
        rgb_d = '0;
        if (aligned.in_img)
            rgb_d = rgb332_to_444(arr.global_rd_data);
        else if (aligned.active)
            rgb_d = rgb444_t'(BORDER_RGB);
        hs_d = aligned.hs ^ ~SYNC_ACT;
        vs_d = aligned.vs ^ ~SYNC_ACT;
        fs_d = aligned.sof;
        if (reset) begin
            rgb_d = '0;
            hs_d  = ~SYNC_ACT;
            vs_d  = ~SYNC_ACT;
            fs_d  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        addr_q <= addr_d;
        dly_q  <= dly_d;
        rgb_q  <= rgb_d;
        hs_q   <= hs_d;
        vs_q   <= vs_d;
        fs_q   <= fs_d;
    end

    assign arr.global_addr = addr_q;
    assign vga_r           = rgb_q.r;
    assign vga_g           = rgb_q.g;
    assign vga_b           = rgb_q.b;
    assign vga_hs          = hs_q;
    assign vga_vs          = vs_q;
    assign frame_start     = fs_q;
endmodule

// File: tb/tb_vga_scanout.sv
// Directed bench for vga_scanout on a shortened raster: sync/frame timing, address map,
// read-latency alignment and reset behaviour against hand-computed values.
module tb_vga_scanout;
    import vga_scanout_pkg::*;

    localparam int H_ACT  = 540;
    localparam int H_FP   = 10;
    localparam int H_SY   = 20;
    localparam int H_BP   = 10;
    localparam int H_TOT  = H_ACT + H_FP + H_SY + H_BP;   // 580
    localparam int V_ACT  = 72;
    localparam int V_FP   = 1;
    localparam int V_SY   = 4;
    localparam int V_BP   = 3;
    localparam int V_TOT  = V_ACT + V_FP + V_SY + V_BP;   // 80
    localparam int FRAME  = H_TOT * V_TOT;                // 46400
    localparam int X0     = 16;
    localparam int Y0     = 4;
    localparam int LAT    = 2;
    localparam logic [11:0] BORDER = 12'h7C3;
    localparam int KEND   = FRAME + 20 * H_TOT + 400;     // counter at (400,20) of frame 2

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       force_ff = 1'b0;
    logic [3:0] vga_r, vga_g, vga_b;
    logic       vga_hs, vga_vs, frame_start;

    int n_tests = 0;
    int n_fail  = 0;

    vga_scanout_if arr_if();

    vga_scanout #(
        .H_ACTIVE(H_ACT), .H_FP(H_FP), .H_SYNC(H_SY), .H_BP(H_BP),
        .V_ACTIVE(V_ACT), .V_FP(V_FP), .V_SYNC(V_SY), .V_BP(V_BP),
        .SYNC_POL(1), .IMG_X0(X0), .IMG_Y0(Y0), .RD_LATENCY(LAT), .BORDER_RGB(BORDER)
    ) dut (
        .clk(clk), .reset(reset), .arr(arr_if),
        .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b),
        .vga_hs(vga_hs), .vga_vs(vga_vs), .frame_start(frame_start)
    );

    always #5 clk = ~clk;

    // Tile array: one register behind the address register, returning addr[7:0] or 8'hFF.
    always_ff @(posedge clk)
        arr_if.global_rd_data <= force_ff ? 8'hFF : arr_if.global_addr[7:0];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic exp_hs(input int pos);
        if (pos < 0) return 1'b0;
        return ((pos % H_TOT) >= H_ACT + H_FP) && ((pos % H_TOT) < H_ACT + H_FP + H_SY);
    endfunction

    function automatic logic exp_vs(input int pos);
        int line;
        if (pos < 0) return 1'b0;
        line = (pos / H_TOT) % V_TOT;
        return (line >= V_ACT + V_FP) && (line < V_ACT + V_FP + V_SY);
    endfunction

    // Address vectors: raster (h,v) -> global_addr, first frame.
    int          ad_h [8] = '{X0, X0+1, X0+64, X0, X0+511, X0+512, X0-1, X0+1};
    int          ad_v [8] = '{Y0, Y0+1, Y0, Y0+64, Y0+67, Y0, Y0+1, Y0-1};
    logic [17:0] ad_e [8] = '{18'h00000, 18'h00041, 18'h01000, 18'h08000,
                              18'h0F0FF, 18'h00000, 18'h00000, 18'h00000};

    // Pixel vectors: frame 0 reads addr[7:0], frame 1 reads 8'hFF.
    int          px_f [12] = '{0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 1};
    int          px_h [12] = '{X0+5, X0+511, X0+512, X0+3, X0-1, X0, 560, X0,
                               X0+5, X0+100, X0+512, 560};
    int          px_v [12] = '{Y0, Y0, Y0, Y0+2, Y0, Y0-1, Y0, V_ACT,
                               Y0, Y0+10, Y0, Y0};
    logic [11:0] px_e [12] = '{12'h025, 12'h2FF, BORDER, 12'h90F, BORDER, BORDER, 12'h000, 12'h000,
                               12'hFFF, 12'hFFF, BORDER, 12'h000};

    initial begin
        int fs_cnt, fs_k1, fs_k2, hs_bad, vs_bad, hs_rise, hs_hi, vs_rise, vs_hi, rst_bad;
        logic hs_prev, vs_prev;
        fs_cnt = 0; fs_k1 = -1; fs_k2 = -1; hs_bad = 0; vs_bad = 0;
        hs_rise = -1; hs_hi = 0; vs_rise = -1; vs_hi = 0; rst_bad = 0;
        hs_prev = 1'b0; vs_prev = 1'b0;

        // Power-on reset
        reset = 1'b1;
        repeat (4) @(posedge clk);
        @(negedge clk);
        check("rst_rgb",  {vga_r, vga_g, vga_b}, 12'h000);
        check("rst_hs",   vga_hs, 1'b0);
        check("rst_vs",   vga_vs, 1'b0);
        check("rst_fs",   frame_start, 1'b0);
        check("rst_addr", arr_if.global_addr, 18'h0);
        reset = 1'b0;

        // First frame plus the start of the second, up to the mid-frame reset point
        for (int k = 1; k <= KEND; k++) begin
            int pos, apos;
            @(negedge clk);
            if (k == FRAME + 10) force_ff = 1'b1;
            pos  = k - (LAT + 1);
            apos = k - 1;
            if (vga_hs !== exp_hs(pos)) hs_bad++;
            if (vga_vs !== exp_vs(pos)) vs_bad++;
            if (frame_start === 1'b1) begin
                fs_cnt++;
                if (fs_cnt == 1) fs_k1 = k;
                if (fs_cnt == 2) fs_k2 = k;
            end
            if (pos >= 0 && pos < H_TOT) begin
                if (vga_hs === 1'b1) hs_hi++;
                if (vga_hs === 1'b1 && !hs_prev && hs_rise < 0) hs_rise = pos;
            end
            if (pos >= 0 && pos < FRAME) begin
                if (vga_vs === 1'b1) vs_hi++;
                if (vga_vs === 1'b1 && !vs_prev && vs_rise < 0) vs_rise = pos;
            end
            hs_prev = vga_hs;
            vs_prev = vga_vs;
            if (apos < FRAME)
                for (int i = 0; i < 8; i++)
                    if (apos == ad_v[i] * H_TOT + ad_h[i])
                        check($sformatf("addr%0d", i), arr_if.global_addr, ad_e[i]);
            if (pos >= 0)
                for (int i = 0; i < 12; i++)
                    if (pos / FRAME == px_f[i] && pos % FRAME == px_v[i] * H_TOT + px_h[i])
                        check($sformatf("pix%0d", i), {vga_r, vga_g, vga_b}, px_e[i]);
        end

        check("fs_first",    fs_k1, LAT + 1);
        check("fs_period",   fs_k2 - fs_k1, FRAME);
        check("fs_count",    fs_cnt, 2);
        check("hs_rise",     hs_rise, H_ACT + H_FP);
        check("hs_width",    hs_hi, H_SY);
        check("hs_pattern",  hs_bad, 0);
        check("vs_rise_ln",  vs_rise / H_TOT, V_ACT + V_FP);
        check("vs_rise_col", vs_rise % H_TOT, 0);
        check("vs_width",    vs_hi, V_SY * H_TOT);
        check("vs_pattern",  vs_bad, 0);

        // Mid-frame reset for 3 clocks at (400,20)
        reset = 1'b1;
        for (int r = 0; r < 3; r++) begin
            @(negedge clk);
            if ({vga_r, vga_g, vga_b} !== 12'h000 || vga_hs !== 1'b0 || vga_vs !== 1'b0 ||
                frame_start !== 1'b0 || arr_if.global_addr !== 18'h0)
                rst_bad++;
        end
        check("mid_rst_outputs", rst_bad, 0);
        reset = 1'b0;

        hs_bad = 0; vs_bad = 0; hs_rise = -1; hs_prev = 1'b0; fs_cnt = 0;
        for (int j = 1; j <= H_TOT + 10; j++) begin
            int pos;
            @(negedge clk);
            pos = j - (LAT + 1);
            if (vga_hs !== exp_hs(pos)) hs_bad++;
            if (vga_vs !== 1'b0) vs_bad++;
            if (frame_start === 1'b1) fs_cnt++;
            if (vga_hs === 1'b1 && !hs_prev && hs_rise < 0) hs_rise = pos;
            hs_prev = vga_hs;
            if (j == LAT)     check("post_rst_blank", {vga_r, vga_g, vga_b}, 12'h000);
            if (j == LAT + 1) begin
                check("post_rst_fs",  frame_start, 1'b1);
                check("post_rst_px0", {vga_r, vga_g, vga_b}, BORDER);
            end
        end
        check("post_rst_fs_cnt", fs_cnt, 1);
        check("post_rst_hs",     hs_bad, 0);
        check("post_rst_hsrise", hs_rise, H_ACT + H_FP);
        check("post_rst_vs",     vs_bad, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
